// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit for the EX stage: shift-add multiply and
// restoring divide on operand magnitudes, with the sign fix applied at commit.
module ex_muldiv #(
  parameter int DATA_WIDTH = 32,
  parameter int ITERS      = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic                  flush,
  output logic                  stall_req,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out,
  output logic                  div_by_zero
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(ITERS + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic [2*W-1:0]  acc_reg;
  logic [W-1:0]    b_mag_reg;
  logic            neg_q_reg, neg_r_reg, b_zero_reg;
  logic            done_reg, busy_reg, dbz_reg;
  logic [W-1:0]    hi_reg, lo_reg;

  logic            last_iter;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      mul_sum, div_shift, div_diff;
  logic [2*W-1:0]  mul_next, div_next, prod_fix;
  logic [W-1:0]    commit_hi, commit_lo;
  logic            commit;

  assign last_iter = (cnt_reg == CW'(ITERS - 1));
  assign a_mag = (op[0] && src_a[W-1]) ? -src_a : src_a;
  assign b_mag = (op[0] && src_b[W-1]) ? -src_b : src_b;

  // One shift-add multiply step: {hi,lo} with the multiplier draining out of lo.
  assign mul_sum  = {1'b0, acc_reg[2*W-1:W]} + {1'b0, (acc_reg[0] ? b_mag_reg : {W{1'b0}})};
  assign mul_next = {mul_sum, acc_reg[W-1:1]};

  // One restoring divide step: {remainder, dividend/quotient} shifted left.
  assign div_shift = acc_reg[2*W-1:W-1];
  assign div_diff  = div_shift - {1'b0, b_mag_reg};
  assign div_next  = div_diff[W] ? {div_shift[W-1:0], acc_reg[W-2:0], 1'b0}
                                 : {div_diff[W-1:0],  acc_reg[W-2:0], 1'b1};

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:  if (start) state_next = op[1] ? S_DIV : S_MUL;
        S_MUL:   if (last_iter) state_next = S_DONE;
        S_DIV:   if (b_zero_reg || last_iter) state_next = S_DONE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_req = (state_reg == S_MUL) || (state_reg == S_DIV) ||
                ((state_reg == S_IDLE) && start);
  end

  // Commit value computed from the final iteration's result.
  always_comb begin
    prod_fix  = neg_q_reg ? -mul_next : mul_next;
    commit_hi = prod_fix[2*W-1:W];
    commit_lo = prod_fix[W-1:0];
    if (state_reg == S_DIV) begin
      if (b_zero_reg) begin
        commit_hi = neg_r_reg ? -acc_reg[W-1:0] : acc_reg[W-1:0];
        commit_lo = {W{1'b1}};
      end else begin
        commit_hi = neg_r_reg ? -div_next[2*W-1:W] : div_next[2*W-1:W];
        commit_lo = neg_q_reg ? -div_next[W-1:0]   : div_next[W-1:0];
      end
    end
  end

  assign commit = (state_next == S_DONE) && (state_reg != S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      acc_reg    <= '0;
      b_mag_reg  <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      b_zero_reg <= 1'b0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      dbz_reg    <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: if (start) begin
          acc_reg    <= {{W{1'b0}}, a_mag};
          b_mag_reg  <= b_mag;
          neg_q_reg  <= op[0] & (src_a[W-1] ^ src_b[W-1]);
          neg_r_reg  <= op[0] & src_a[W-1];
          b_zero_reg <= (src_b == '0);
          cnt_reg    <= '0;
        end
        S_MUL: begin
          acc_reg <= mul_next;
          cnt_reg <= cnt_reg + 1'b1;
        end
        S_DIV: begin
          acc_reg <= div_next;
          cnt_reg <= cnt_reg + 1'b1;
        end
        default: ;
      endcase
      if (commit) begin
        hi_reg  <= commit_hi;
        lo_reg  <= commit_lo;
        dbz_reg <= (state_reg == S_DIV) && b_zero_reg;
      end
      done_reg <= (state_next == S_DONE);
      busy_reg <= (state_next == S_MUL) || (state_next == S_DIV);
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign hi_out      = hi_reg;
  assign lo_out      = lo_reg;
  assign div_by_zero = dbz_reg;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: latency, stall window, results, flush and reset.
module tb_ex_muldiv;
  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        stall_req, busy, done, div_by_zero;
  logic [31:0] hi_out, lo_out;

  int total = 0;
  int bad   = 0;

  ex_muldiv dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .stall_req(stall_req), .busy(busy), .done(done),
    .hi_out(hi_out), .lo_out(lo_out), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Issue one op in cycle 1 and follow it to its done cycle.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                       input logic edbz, input int elat);
    int cyc;
    int nstall;
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    #1;
    cyc = 1;
    nstall = stall_req ? 1 : 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      cyc++;
      if (!done && stall_req) nstall++;
    end
    check({tag, ".lat"}, 64'(cyc), 64'(elat));
    check({tag, ".stall_cycles"}, 64'(nstall), 64'(elat - 1));
    check({tag, ".stall_in_done"}, 64'(stall_req), 64'd0);
    check({tag, ".hi"}, 64'(hi_out), 64'(eh));
    check({tag, ".lo"}, 64'(lo_out), 64'(el));
    check({tag, ".dbz"}, 64'(div_by_zero), 64'(edbz));
    @(negedge clk);
    #1;
    check({tag, ".done_pulse"}, 64'(done), 64'd0);
    check({tag, ".hold"}, {hi_out, lo_out}, {eh, el});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset.outs", {29'd0, busy, done, div_by_zero, hi_out, lo_out}, 64'd0);
    check("reset.stall", 64'(stall_req), 64'd0);
    rst = 1'b0;

    do_op("multu_ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34);
    do_op("mult_m3x7", 2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34);
    do_op("mult_min2", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34);
    do_op("div_m7d2", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
    do_op("divu_100d7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);
    do_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34);
    do_op("divu_5d0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 3);
    do_op("div_m8d0", 2'b11, 32'hFFFFFFF8, 32'd0, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 3);
    do_op("divu_7d100", 2'b10, 32'd7, 32'd100, 32'd7, 32'd0, 1'b0, 34);

    // Flush at DIV iteration 10 (cycle 11).
    @(negedge clk);
    op = 2'b10; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    check("flush.busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush.busy", 64'(busy), 64'd0);
    check("flush.done", 64'(done), 64'd0);
    check("flush.stall", 64'(stall_req), 64'd0);
    check("flush.hold", {hi_out, lo_out}, {32'd7, 32'd0});
    do_op("after_flush", 2'b10, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 34);

    // flush beats a simultaneous start.
    @(negedge clk);
    op = 2'b00; src_a = 32'd2; src_b = 32'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check("flush_start.busy", 64'(busy), 64'd0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    op = 2'b01; src_a = 32'd12345; src_b = 32'd678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid.outs", {29'd0, busy, done, div_by_zero, hi_out, lo_out}, 64'd0);
    check("rst_mid.stall", 64'(stall_req), 64'd0);
    repeat (40) @(negedge clk);
    #1;
    check("rst_mid.no_done", 64'(done | busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
